// File: rtl/ssm_pkg.sv
// Shared definitions for the shift-and-add modular multiplier family:
// sequencer/multiplier state encodings, default widths and an index-width helper.
package ssm_pkg;

    localparam int SSM_W_DEF = 8;
    localparam int SSM_E_DEF = 8;

    typedef enum logic [2:0] {
        MX_IDLE     = 3'd0,
        MX_CHECK    = 3'd1,
        MX_SQ_GO    = 3'd2,
        MX_SQ_WAIT  = 3'd3,
        MX_MUL_GO   = 3'd4,
        MX_MUL_WAIT = 3'd5,
        MX_NEXT     = 3'd6,
        MX_DONE     = 3'd7
    } mx_state_e;

    typedef enum logic [1:0] {
        MM_IDLE = 2'd0,
        MM_BUSY = 2'd1,
        MM_FIN  = 2'd2
    } mm_state_e;

    // Bit index width for an e-bit exponent (at least one bit).
    function automatic int unsigned idx_width(input int unsigned e);
        return (e > 32'd1) ? $clog2(e) : 32'd1;
    endfunction

endpackage

// File: rtl/ssm_lead_one.sv
// Combinational priority encoder: index of the highest set bit of vec,
// with zero=1 when no bit is set (idx is then 0).
module ssm_lead_one
    import ssm_pkg::*;
#(
    parameter int E = SSM_E_DEF
) (
    input  logic [E-1:0]              vec,
    output logic [idx_width(E)-1:0]   idx,
    output logic                      zero
);

    localparam int unsigned IW = idx_width(E);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx  = '0;
        zero = 1'b1;
        for (int i = 0; i < E; i++) begin
            idx  = vec[i] ? IW'(i) : idx;
            zero = zero & ~vec[i];
        end
    end

endmodule

// File: rtl/ssm_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving the ssm modular multiplier.
// Optional build macro SSM_SKIP_LZ_EN: skip squarings of leading exponent zeros.
module ssm_modexp_ctrl
    import ssm_pkg::*;
#(
    parameter int W = SSM_W_DEF,
    parameter int E = SSM_E_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] base,
    input  logic [E-1:0] exp,
    input  logic [W-1:0] modn,
    output logic         ready,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result,
    output logic         mm_start,
    output logic [W-1:0] mm_a,
    output logic [W-1:0] mm_b,
    output logic [W-1:0] mm_n,
    input  logic         mm_ready,
    input  logic [W-1:0] mm_p
);

    localparam int unsigned IW = idx_width(E);

    mx_state_e       state_q, state_d;
    logic [W-1:0]    base_q, base_d;
    logic [E-1:0]    exp_q, exp_d;
    logic [W-1:0]    modn_q, modn_d;
    logic [W-1:0]    r_q, r_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            first_q, first_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [W-1:0]    result_q, result_d;
    logic            mm_start_q, mm_start_d;
    logic [W-1:0]    mm_a_q, mm_a_d;
    logic [W-1:0]    mm_b_q, mm_b_d;

`ifdef SSM_SKIP_LZ_EN
    logic [IW-1:0]   lz_idx_s;
    logic            lz_zero_s;

    ssm_lead_one #(.E(E)) u_lead_one (
        .vec  (exp_q),
        .idx  (lz_idx_s),
        .zero (lz_zero_s)
    );
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MX_IDLE;
            base_q     <= '0;
            exp_q      <= '0;
            modn_q     <= '0;
            r_q        <= '0;
            idx_q      <= '0;
            first_q    <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            exp_q      <= exp_d;
            modn_q     <= modn_d;
            r_q        <= r_d;
            idx_q      <= idx_d;
            first_q    <= first_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            result_q   <= result_d;
            mm_start_q <= mm_start_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        exp_d    = exp_q;
        modn_d   = modn_q;
        r_d      = r_q;
        idx_d    = idx_q;
        first_d  = 1'b0;
        err_d    = err_q;
        result_d = result_q;
        mm_a_d   = mm_a_q;
        mm_b_d   = mm_b_q;

        case (state_q)
            MX_IDLE: begin
                if (start) begin
                    base_d   = base;
                    exp_d    = exp;
                    modn_d   = modn;
                    err_d    = 1'b0;
                    result_d = '0;
                    state_d  = MX_CHECK;
                end else begin
                    state_d  = MX_IDLE;
                end
            end
            MX_CHECK: begin
                if ((modn_q == W'(0)) || (base_q >= modn_q)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = MX_DONE;
                end else begin
                    r_d    = (modn_q == W'(1)) ? W'(0) : W'(1);
                    mm_a_d = r_d;
                    mm_b_d = r_d;
`ifdef SSM_SKIP_LZ_EN
                    if (lz_zero_s) begin
                        result_d = r_d;
                        state_d  = MX_DONE;
                    end else begin
                        idx_d    = lz_idx_s;
                        state_d  = MX_SQ_GO;
                    end
`else
                    idx_d   = IW'(E - 1);
                    state_d = MX_SQ_GO;
`endif
                end
            end
            MX_SQ_GO: begin
                first_d = 1'b1;
                state_d = MX_SQ_WAIT;
            end
            // First wait cycle sees the multiplier's stale idle status, so it never completes.
            MX_SQ_WAIT: begin
                if (mm_ready && !first_q) begin
                    r_d = mm_p;
                    if (exp_q[idx_q]) begin
                        mm_a_d  = mm_p;
                        mm_b_d  = base_q;
                        state_d = MX_MUL_GO;
                    end else begin
                        state_d = MX_NEXT;
                    end
                end else begin
                    state_d = MX_SQ_WAIT;
                end
            end
            MX_MUL_GO: begin
                first_d = 1'b1;
                state_d = MX_MUL_WAIT;
            end
            MX_MUL_WAIT: begin
                if (mm_ready && !first_q) begin
                    r_d     = mm_p;
                    state_d = MX_NEXT;
                end else begin
                    state_d = MX_MUL_WAIT;
                end
            end
            MX_NEXT: begin
                if (idx_q == IW'(0)) begin
                    result_d = r_q;
                    state_d  = MX_DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    mm_a_d  = r_q;
                    mm_b_d  = r_q;
                    state_d = MX_SQ_GO;
                end
            end
            MX_DONE: begin
                state_d = MX_IDLE;
            end
            default: begin
                state_d = MX_IDLE;
            end
        endcase

        ready_d    = (state_d == MX_IDLE);
        done_d     = (state_d == MX_DONE);
        mm_start_d = (state_d == MX_SQ_GO) || (state_d == MX_MUL_GO);
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign err      = err_q;
    assign result   = result_q;
    assign mm_start = mm_start_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_n     = modn_q;

endmodule
